// File: rtl/load_store_unit_if.sv
// Pipeline-to-LSU request/response handshake plus the LSU's byte-addressed memory port.
// Handshake rule: a transfer happens on a rising clk edge where valid && ready are both 1; a source keeps valid and its payload stable until that edge.
interface load_store_unit_if #(parameter int ADDR_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_data;
  logic              resp_err;

  logic [ADDR_W-1:0] mem_rd_addr;
  logic [31:0]       mem_rd_data;
  logic [1:0]        mem_wr;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [31:0]       mem_wr_data;

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready, mem_rd_data,
    input  req_ready, resp_valid, resp_data, resp_err, mem_rd_addr, mem_wr, mem_wr_addr, mem_wr_data
  );

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready, mem_rd_data,
    output req_ready, resp_valid, resp_data, resp_err, mem_rd_addr, mem_wr, mem_wr_addr, mem_wr_data
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding request, alignment/legality checks, single-pulse writes,
// sign/zero-extended loads over a one-cycle-latency memory read port.
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  load_store_unit_if.slave    bus,
  output logic [2:0]          state_dbg
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    RD_CAP   = 3'd2,
    ST_ISSUE = 3'd3,
    RESP     = 3'd4
  } state_t;

  state_t            state;
  logic [2:0]        funct3_q;

  logic [ADDR_W-1:0] addr_in;
  logic [2:0]        f3_in;
  logic              illegal;
  logic              misaligned;
  logic [1:0]        wr_size;
  logic [31:0]       wr_data_masked;
  logic [31:0]       load_data;

  assign addr_in   = bus.req_addr;
  assign f3_in     = bus.req_funct3;
  assign state_dbg = state;

  // funct3[1:0] encodes access size for both loads and stores (0 byte, 1 half, 2 word).
  always_comb begin
    illegal        = 1'b0;
    misaligned     = 1'b0;
    wr_size        = 2'd0;
    wr_data_masked = 32'd0;
    if (bus.req_store) illegal = (f3_in > 3'd2);
    else               illegal = (f3_in == 3'd3) || (f3_in == 3'd6) || (f3_in == 3'd7);
    misaligned = ((f3_in[1:0] == 2'd1) && addr_in[0]) ||
                 ((f3_in[1:0] == 2'd2) && (addr_in[1:0] != 2'b00));
    case (f3_in[1:0])
      2'd0:    begin wr_size = 2'd1; wr_data_masked = {24'd0, bus.req_wdata[7:0]};  end
      2'd1:    begin wr_size = 2'd2; wr_data_masked = {16'd0, bus.req_wdata[15:0]}; end
      default: begin wr_size = 2'd3; wr_data_masked = bus.req_wdata;                end
    endcase
  end

  always_comb begin
    load_data = 32'd0;
    case (funct3_q)
      3'd0:    load_data = {{24{bus.mem_rd_data[7]}},  bus.mem_rd_data[7:0]};
      3'd1:    load_data = {{16{bus.mem_rd_data[15]}}, bus.mem_rd_data[15:0]};
      3'd2:    load_data = bus.mem_rd_data;
      3'd4:    load_data = {24'd0, bus.mem_rd_data[7:0]};
      3'd5:    load_data = {16'd0, bus.mem_rd_data[15:0]};
      default: load_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      funct3_q        <= 3'd0;
      bus.req_ready   <= 1'b1;
      bus.resp_valid  <= 1'b0;
      bus.resp_err    <= 1'b0;
      bus.resp_data   <= 32'd0;
      bus.mem_wr      <= 2'd0;
      bus.mem_rd_addr <= '0;
      bus.mem_wr_addr <= '0;
      bus.mem_wr_data <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            bus.req_ready <= 1'b0;
            funct3_q      <= f3_in;
            if (illegal || misaligned) begin
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_data  <= 32'd0;
              state          <= RESP;
            end else if (bus.req_store) begin
              bus.mem_wr      <= wr_size;
              bus.mem_wr_addr <= addr_in;
              bus.mem_wr_data <= wr_data_masked;
              state           <= ST_ISSUE;
            end else begin
              bus.mem_rd_addr <= addr_in;
              state           <= RD_WAIT;
            end
          end
        end
        RD_WAIT: state <= RD_CAP;
        RD_CAP: begin
          bus.resp_data  <= load_data;
          bus.resp_err   <= 1'b0;
          bus.resp_valid <= 1'b1;
          state          <= RESP;
        end
        ST_ISSUE: begin
          bus.mem_wr     <= 2'd0;
          bus.resp_data  <= 32'd0;
          bus.resp_err   <= 1'b0;
          bus.resp_valid <= 1'b1;
          state          <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.req_ready  <= 1'b1;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: byte-array memory model with one-cycle read latency,
// per-feature test tasks with inline checks, outputs sampled on the falling edge.
module tb_load_store_unit;

  logic clk;
  logic rst;
  logic [2:0] state_dbg;

  int n_vec = 0;
  int n_err = 0;
  int wr_count = 0;

  logic [31:0] exp_q[$];

  logic       bd_we;
  logic [7:0] bd_addr;
  logic [7:0] bd_data;
  logic [7:0] mem [0:255];
  logic [7:0] ra;
  logic [7:0] wa;

  load_store_unit_if #(.ADDR_W(32)) bus ();

  load_store_unit #(.ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ra = bus.mem_rd_addr[7:0];
  assign wa = bus.mem_wr_addr[7:0];

  // Memory model: registered read (address in cycle C, data in C+1), writes at the edge.
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    case (bus.mem_wr)
      2'd1: mem[wa] <= bus.mem_wr_data[7:0];
      2'd2: begin mem[wa] <= bus.mem_wr_data[7:0]; mem[wa + 8'd1] <= bus.mem_wr_data[15:8]; end
      2'd3: begin
        mem[wa]        <= bus.mem_wr_data[7:0];
        mem[wa + 8'd1] <= bus.mem_wr_data[15:8];
        mem[wa + 8'd2] <= bus.mem_wr_data[23:16];
        mem[wa + 8'd3] <= bus.mem_wr_data[31:24];
      end
      default: ;
    endcase
    if (bus.mem_wr != 2'd0) wr_count <= wr_count + 1;
    bus.mem_rd_data <= {mem[ra + 8'd3], mem[ra + 8'd2], mem[ra + 8'd1], mem[ra]};
  end

  // ---------------- driver tasks (start and end on a falling edge) ----------------
  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic drive_req(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    bus.req_valid = 1'b1; bus.req_store = st; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = wd;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp();
    for (int i = 0; i < 20; i++) begin
      if (bus.resp_valid === 1'b1) break;
      @(negedge clk);
    end
  endtask

  task automatic finish_resp();
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL rst_req_ready: got %b want 1", bus.req_ready); end
    n_vec++; if (bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid: got %b want 0", bus.resp_valid); end
    n_vec++; if (bus.resp_err !== 1'b0) begin n_err++; $display("FAIL rst_resp_err: got %b want 0", bus.resp_err); end
    n_vec++; if (bus.resp_data !== 32'd0) begin n_err++; $display("FAIL rst_resp_data: got %h want 0", bus.resp_data); end
    n_vec++; if (bus.mem_wr !== 2'd0) begin n_err++; $display("FAIL rst_mem_wr: got %0d want 0", bus.mem_wr); end
    n_vec++; if (bus.mem_rd_addr !== 32'd0) begin n_err++; $display("FAIL rst_mem_rd_addr: got %h want 0", bus.mem_rd_addr); end
    n_vec++; if (bus.mem_wr_addr !== 32'd0) begin n_err++; $display("FAIL rst_mem_wr_addr: got %h want 0", bus.mem_wr_addr); end
    n_vec++; if (bus.mem_wr_data !== 32'd0) begin n_err++; $display("FAIL rst_mem_wr_data: got %h want 0", bus.mem_wr_data); end
    n_vec++; if (state_dbg !== 3'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", state_dbg); end
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b want 1", bus.req_ready); end
  endtask

  task automatic test_load_sign();
    poke(8'h10, 8'h80);
    drive_req(1'b0, 3'd0, 32'h10, 32'd0);
    n_vec++; if (bus.mem_rd_addr !== 32'h10) begin n_err++; $display("FAIL lb_rd_addr: got %h want 10", bus.mem_rd_addr); end
    n_vec++; if (state_dbg !== 3'd1) begin n_err++; $display("FAIL lb_state_n1: got %0d want 1", state_dbg); end
    n_vec++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL lb_req_ready_busy: got %b want 0", bus.req_ready); end
    n_vec++; if (bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL lb_valid_n1: got %b want 0", bus.resp_valid); end
    @(negedge clk);
    n_vec++; if (bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL lb_valid_n2: got %b want 0", bus.resp_valid); end
    @(negedge clk);
    n_vec++; if (bus.resp_valid !== 1'b1) begin n_err++; $display("FAIL lb_valid_n3: got %b want 1", bus.resp_valid); end
    n_vec++; if (bus.resp_data !== 32'hFFFFFF80) begin n_err++; $display("FAIL lb_data: got %h want ffffff80", bus.resp_data); end
    n_vec++; if (bus.resp_err !== 1'b0) begin n_err++; $display("FAIL lb_err: got %b want 0", bus.resp_err); end
    finish_resp();
    n_vec++; if (bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL lb_valid_after: got %b want 0", bus.resp_valid); end
    n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL lb_ready_after: got %b want 1", bus.req_ready); end
    drive_req(1'b0, 3'd4, 32'h10, 32'd0);
    @(negedge clk); @(negedge clk);
    n_vec++; if (bus.resp_valid !== 1'b1) begin n_err++; $display("FAIL lbu_valid_n3: got %b want 1", bus.resp_valid); end
    n_vec++; if (bus.resp_data !== 32'h00000080) begin n_err++; $display("FAIL lbu_data: got %h want 00000080", bus.resp_data); end
    finish_resp();
  endtask

  task automatic test_store_load();
    int w0;
    w0 = wr_count;
    n_vec++; if (bus.mem_wr !== 2'd0) begin n_err++; $display("FAIL sw_idle_wr: got %0d want 0", bus.mem_wr); end
    drive_req(1'b1, 3'd2, 32'h20, 32'hDEADBEEF);
    n_vec++; if (bus.mem_wr !== 2'd3) begin n_err++; $display("FAIL sw_mem_wr: got %0d want 3", bus.mem_wr); end
    n_vec++; if (bus.mem_wr_addr !== 32'h20) begin n_err++; $display("FAIL sw_wr_addr: got %h want 20", bus.mem_wr_addr); end
    n_vec++; if (bus.mem_wr_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL sw_wr_data: got %h want deadbeef", bus.mem_wr_data); end
    @(negedge clk);
    n_vec++; if (bus.mem_wr !== 2'd0) begin n_err++; $display("FAIL sw_wr_pulse_end: got %0d want 0", bus.mem_wr); end
    n_vec++; if (bus.resp_valid !== 1'b1) begin n_err++; $display("FAIL sw_resp_valid: got %b want 1", bus.resp_valid); end
    n_vec++; if (bus.resp_data !== 32'd0 || bus.resp_err !== 1'b0) begin n_err++; $display("FAIL sw_resp: got data %h err %b want 0/0", bus.resp_data, bus.resp_err); end
    finish_resp();
    n_vec++; if (wr_count !== w0 + 1) begin n_err++; $display("FAIL sw_pulse_count: got %0d want %0d", wr_count - w0, 1); end
    drive_req(1'b0, 3'd2, 32'h20, 32'd0);
    wait_resp();
    n_vec++; if (bus.resp_valid !== 1'b1) begin n_err++; $display("FAIL lw_timeout: resp_valid %b want 1", bus.resp_valid); end
    n_vec++; if (bus.resp_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL lw_data: got %h want deadbeef", bus.resp_data); end
    finish_resp();
  endtask

  task automatic test_errors();
    int w0;
    w0 = wr_count;
    drive_req(1'b0, 3'd1, 32'h21, 32'd0);
    n_vec++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1) begin n_err++; $display("FAIL lh_mis_err: got valid %b err %b want 1/1", bus.resp_valid, bus.resp_err); end
    n_vec++; if (bus.resp_data !== 32'd0) begin n_err++; $display("FAIL lh_mis_data: got %h want 0", bus.resp_data); end
    finish_resp();
    drive_req(1'b1, 3'd2, 32'h22, 32'h12345678);
    n_vec++; if (bus.mem_wr !== 2'd0) begin n_err++; $display("FAIL sw_mis_wr: got %0d want 0", bus.mem_wr); end
    n_vec++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1) begin n_err++; $display("FAIL sw_mis_err: got valid %b err %b want 1/1", bus.resp_valid, bus.resp_err); end
    n_vec++; if (bus.resp_data !== 32'd0) begin n_err++; $display("FAIL sw_mis_data: got %h want 0", bus.resp_data); end
    finish_resp();
    drive_req(1'b0, 3'd3, 32'h24, 32'd0);
    n_vec++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1) begin n_err++; $display("FAIL ld_f3_3_err: got valid %b err %b want 1/1", bus.resp_valid, bus.resp_err); end
    finish_resp();
    n_vec++; if (wr_count !== w0) begin n_err++; $display("FAIL err_no_write: got %0d writes want 0", wr_count - w0); end
  endtask

  task automatic test_backpressure();
    int w0;
    drive_req(1'b0, 3'd2, 32'h20, 32'd0);
    wait_resp();
    n_vec++; if (bus.resp_valid !== 1'b1) begin n_err++; $display("FAIL bp_timeout: resp_valid %b want 1", bus.resp_valid); end
    w0 = wr_count;
    bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'h40; bus.req_wdata = 32'h123456AB;
    for (int i = 0; i < 5; i++) begin
      n_vec++; if (bus.resp_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, bus.resp_valid); end
      n_vec++; if (bus.resp_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL bp_hold_data[%0d]: got %h want deadbeef", i, bus.resp_data); end
      n_vec++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL bp_req_ready[%0d]: got %b want 0", i, bus.req_ready); end
      @(negedge clk);
    end
    finish_resp();
    n_vec++; if (state_dbg !== 3'd0) begin n_err++; $display("FAIL bp_state_idle: got %0d want 0", state_dbg); end
    n_vec++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin n_err++; $display("FAIL bp_after_hs: got valid %b ready %b want 0/1", bus.resp_valid, bus.req_ready); end
    n_vec++; if (wr_count !== w0) begin n_err++; $display("FAIL bp_early_accept: got %0d writes want 0", wr_count - w0); end
    @(negedge clk);
    bus.req_valid = 1'b0;
    n_vec++; if (bus.mem_wr !== 2'd1) begin n_err++; $display("FAIL bp_sb_wr: got %0d want 1", bus.mem_wr); end
    n_vec++; if (bus.mem_wr_addr !== 32'h40) begin n_err++; $display("FAIL bp_sb_addr: got %h want 40", bus.mem_wr_addr); end
    n_vec++; if (bus.mem_wr_data !== 32'h000000AB) begin n_err++; $display("FAIL bp_sb_data: got %h want 000000ab", bus.mem_wr_data); end
    wait_resp();
    finish_resp();
    n_vec++; if (wr_count !== w0 + 1) begin n_err++; $display("FAIL bp_single_accept: got %0d writes want 1", wr_count - w0); end
  endtask

  task automatic test_reset_mid_store();
    int w0;
    drive_req(1'b1, 3'd1, 32'h30, 32'hAAAA1234);
    w0 = wr_count;
    n_vec++; if (bus.mem_wr !== 2'd2) begin n_err++; $display("FAIL sh_mem_wr: got %0d want 2", bus.mem_wr); end
    n_vec++; if (bus.mem_wr_data !== 32'h00001234) begin n_err++; $display("FAIL sh_wr_data: got %h want 00001234", bus.mem_wr_data); end
    #1 rst = 1'b1;
    #1;
    n_vec++; if (bus.mem_wr !== 2'd0) begin n_err++; $display("FAIL rst_async_wr: got %0d want 0", bus.mem_wr); end
    n_vec++; if (state_dbg !== 3'd0 || bus.req_ready !== 1'b1) begin n_err++; $display("FAIL rst_async_state: got state %0d ready %b want 0/1", state_dbg, bus.req_ready); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin n_err++; $display("FAIL rst_abandon[%0d]: got valid %b ready %b want 0/1", i, bus.resp_valid, bus.req_ready); end
    end
    n_vec++; if (wr_count !== w0) begin n_err++; $display("FAIL rst_no_write: got %0d writes want 0", wr_count - w0); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    poke(8'h02, 8'h01);
    exp_q.push_back(32'h00000000);
    exp_q.push_back(32'h00007F01);
    bus.resp_ready = 1'b1;
    drive_req(1'b1, 3'd0, 32'h3, 32'h0000007F);
    wait_resp();
    exp = exp_q.pop_front();
    n_vec++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== exp) begin n_err++; $display("FAIL b2b_sb_resp: got valid %b data %h want 1/%h", bus.resp_valid, bus.resp_data, exp); end
    @(negedge clk);
    n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready: got %b want 1", bus.req_ready); end
    drive_req(1'b0, 3'd1, 32'h2, 32'd0);
    wait_resp();
    exp = exp_q.pop_front();
    n_vec++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== exp) begin n_err++; $display("FAIL b2b_lh_resp: got valid %b data %h want 1/%h", bus.resp_valid, bus.resp_data, exp); end
    @(negedge clk);
    bus.resp_ready = 1'b0;
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_queue: got %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bd_we = 1'b0; bd_addr = 8'd0; bd_data = 8'd0;
    bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.resp_ready = 1'b0;
    test_reset();
    test_load_sign();
    test_store_load();
    test_errors();
    test_backpressure();
    test_reset_mid_store();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the width of all address ports.
REQ-002 The block SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 The block SHALL have port req_valid, input, 1, pipeline request present.
REQ-005 The block SHALL have port req_ready, output, 1, request accepted when req_valid && req_ready at a rising edge.
REQ-006 The block SHALL have port req_store, input, 1, 1 = store, 0 = load.
REQ-007 The block SHALL have port req_funct3, input, 3, RV32I width/sign code (0 B, 1 H, 2 W, 4 BU, 5 HU).
REQ-008 The block SHALL have ports req_addr (input, ADDR_W, byte address) and req_wdata (input, 32, store data in low bits).
REQ-009 The block SHALL have ports resp_valid (output, 1), resp_ready (input, 1), resp_data (output, 32) and resp_err (output, 1) for the response handshake.
REQ-010 The block SHALL have ports mem_rd_addr (output, ADDR_W) and mem_rd_data (input, 32) to the byte-addressed memory; mem_rd_data byte k is the byte at mem_rd_addr+k.
REQ-011 The block SHALL have ports mem_wr (output, 2; 0 none, 1 byte, 2 half, 3 word), mem_wr_addr (output, ADDR_W) and mem_wr_data (output, 32) to the memory.

Function
REQ-012 Memory read latency SHALL be: mem_rd_addr stable in cycle C gives valid mem_rd_data in cycle C+1.
REQ-013 States SHALL be IDLE, RD_WAIT, RD_CAP, ST_ISSUE, RESP; req_ready = 1 only in IDLE.
REQ-014 In IDLE, an accepted request SHALL latch addr, funct3, store flag and wdata.
REQ-015 Misalignment SHALL be H/HU/SH with addr[0]=1, or W/SW with addr[1:0]!=0; illegal SHALL be load funct3 3/6/7, or store funct3 >2.
REQ-016 A misaligned or illegal request SHALL make no memory access and go IDLE->RESP with resp_err=1 and resp_data=0.
REQ-017 An aligned load accepted in cycle N SHALL drive registered mem_rd_addr=addr from cycle N+1 (RD_WAIT), sample mem_rd_data in N+2 (RD_CAP), and present resp_valid from N+3 (RESP).
REQ-018 Load data SHALL be: B sign-extends [7:0]; H sign-extends [15:0]; W passes [31:0]; BU/HU zero-extend [7:0]/[15:0].
REQ-019 An aligned store accepted in cycle N SHALL drive mem_wr (1/2/3 for SB/SH/SW), mem_wr_addr=addr and mem_wr_data for exactly cycle N+1 (ST_ISSUE), then RESP from N+2 with resp_data=0 and resp_err=0.
REQ-020 mem_wr_data SHALL carry only the stored bytes, with unused upper bytes 0.
REQ-021 mem_wr SHALL be 0 in every state except ST_ISSUE, so at most one write pulse occurs per store.
REQ-022 In RESP, resp_valid=1 and resp_data/resp_err SHALL stay stable until resp_valid && resp_ready at an edge, then go to IDLE with resp_valid=0.
REQ-023 req_valid outside IDLE SHALL be ignored, and no request is lost or duplicated.
REQ-024 Address arithmetic SHALL be modulo 2^ADDR_W; the unit never adds offsets itself.

Reset
REQ-025 rst=1 SHALL immediately, without a clock, force state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_data=0, mem_wr=0, mem_rd_addr=0, mem_wr_addr=0 and mem_wr_data=0.
REQ-026 Reset asserted mid-operation (RD_WAIT, ST_ISSUE, RESP) SHALL abandon the transaction with no response; a store in ST_ISSUE has its mem_wr pulse truncated to 0 at once.

Verification
REQ-027 Bench SHALL check: mem byte at 0x10 = 0x80, LB at 0x10 -> resp_data=0xFFFFFF80 in cycle N+3; LBU -> 0x00000080.
REQ-028 Bench SHALL check: SW 0xDEADBEEF at 0x20 -> single-cycle mem_wr=3, mem_wr_addr=0x20, mem_wr_data=0xDEADBEEF; then LW at 0x20 -> 0xDEADBEEF.
REQ-029 Bench SHALL check: LH at 0x21 and SW at 0x22 -> resp_err=1, resp_data=0, mem_wr never nonzero; load funct3=3 -> resp_err=1.
REQ-030 Bench SHALL check: resp_ready held 0 for 5 cycles -> resp_valid and resp_data hold, req_ready=0, and a second req_valid is not accepted until after the handshake.
REQ-031 Bench SHALL check: rst pulsed while mem_wr=2 in ST_ISSUE -> mem_wr=0 before the next clock edge, no resp_valid, and req_ready=1 after release.
REQ-032 Bench SHALL check: back-to-back SB 0x7F at 0x3 then LH at 0x2 (byte 0x2 = 0x01) -> resp_data=0x00007F01.
